// File: rtl/idex_latch.sv
// ID/EX pipeline latch with load-use hazard detection, branch flush (deferred
// across memory-wait holds), saturating bubble/flush counters and a RUN/HOLD tracker.
module idex_latch (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_wsel,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        id_i_type,
  input  logic        id_uses_rt,
  input  logic        id_valid,
  input  logic [31:0] id_rdat1,
  input  logic [31:0] id_rdat2,
  input  logic [31:0] id_imm,
  input  logic [3:0]  id_aluop,
  input  logic        ihit,
  input  logic        mem_wait,
  input  logic        flush,
  output logic [4:0]  idex_rs_out,
  output logic [4:0]  idex_rt_out,
  output logic [4:0]  idex_wsel_out,
  output logic        idex_RegWrite_out,
  output logic        idex_MemRead_out,
  output logic        idex_MemWrite_out,
  output logic        i_type,
  output logic        idex_valid_out,
  output logic [31:0] idex_rdat1_out,
  output logic [31:0] idex_rdat2_out,
  output logic [31:0] idex_imm_out,
  output logic [3:0]  idex_aluop_out,
  output logic        stall_o,
  output logic        state_o,
  output logic [15:0] bubble_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wsel;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        i_type;
    logic        valid;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [3:0]  aluop;
  } idex_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  idex_t       idex_q, idex_d, id_s;
  logic        flush_pend_q, flush_pend_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        advance_s, flush_eff_s, hazard_s;

  assign id_s = '{rs: id_rs, rt: id_rt, wsel: id_wsel, reg_write: id_RegWrite,
                  mem_read: id_MemRead, mem_write: id_MemWrite, i_type: id_i_type,
                  valid: id_valid, rdat1: id_rdat1, rdat2: id_rdat2, imm: id_imm,
                  aluop: id_aluop};

  // A load in EX whose nonzero destination is read by the ID instruction
  assign advance_s   = ihit & ~mem_wait;
  assign flush_eff_s = flush | flush_pend_q;
  assign hazard_s    = idex_q.valid & idex_q.mem_read & (idex_q.wsel != 5'd0) &
                       ((idex_q.wsel == id_rs) | (id_uses_rt & (idex_q.wsel == id_rt))) &
                       id_valid;
  assign stall_o     = hazard_s & ~flush_eff_s;

  // Next-state for the latch, counters and the deferred flush
  always_comb begin
    idex_d       = idex_q;
    flush_pend_d = flush_pend_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (advance_s) begin
      flush_pend_d = 1'b0;
      if (flush_eff_s) begin
        idex_d      = '0;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (hazard_s) begin
        idex_d       = '0;
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end else begin
        idex_d = id_s;
      end
    end else begin
      flush_pend_d = flush_pend_q | flush;
    end
  end

  // RUN/HOLD next state follows the dcache wait
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = mem_wait ? HOLD : RUN;
      HOLD:    state_d = mem_wait ? HOLD : RUN;
      default: state_d = RUN;
    endcase
  end

  // State registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= RUN;
      idex_q       <= '0;
      flush_pend_q <= 1'b0;
      bubble_cnt_q <= 16'd0;
      flush_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      idex_q       <= idex_d;
      flush_pend_q <= flush_pend_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign idex_rs_out       = idex_q.rs;
  assign idex_rt_out       = idex_q.rt;
  assign idex_wsel_out     = idex_q.wsel;
  assign idex_RegWrite_out = idex_q.reg_write;
  assign idex_MemRead_out  = idex_q.mem_read;
  assign idex_MemWrite_out = idex_q.mem_write;
  assign i_type            = idex_q.i_type;
  assign idex_valid_out    = idex_q.valid;
  assign idex_rdat1_out    = idex_q.rdat1;
  assign idex_rdat2_out    = idex_q.rdat2;
  assign idex_imm_out      = idex_q.imm;
  assign idex_aluop_out    = idex_q.aluop;
  assign state_o           = state_q;
  assign bubble_cnt        = bubble_cnt_q;
  assign flush_cnt         = flush_cnt_q;

endmodule
